// File: rtl/jt12_sched_pkg.sv
// Shared constants and slot-decode helpers for the accumulator slot sequencer.
package jt12_sched_pkg;

    localparam int NUM_CH = 6;
    localparam int SLOTS  = NUM_CH * 4;

    localparam logic [4:0] S1_BASE = 5'd0;
    localparam logic [4:0] S3_BASE = 5'd6;
    localparam logic [4:0] S2_BASE = 5'd12;
    localparam logic [4:0] S4_BASE = 5'd18;

    localparam logic [1:0] RL_RST = 2'b11;

    // Operator group of a slot: 0=S1, 1=S3, 2=S2, 3=S4 (frame order)
    function automatic logic [1:0] slot_group(input logic [4:0] slot);
        logic [1:0] grp;
        if (slot >= S4_BASE) begin
            grp = 2'd3;
        end else if (slot >= S2_BASE) begin
            grp = 2'd2;
        end else if (slot >= S3_BASE) begin
            grp = 2'd1;
        end else begin
            grp = 2'd0;
        end
        return grp;
    endfunction

    // Channel of a slot, i.e. its offset inside its operator group
    function automatic logic [2:0] slot_ch(input logic [4:0] slot);
        logic [4:0] off;
        case (slot_group(slot))
            2'd3:    off = slot - S4_BASE;
            2'd2:    off = slot - S2_BASE;
            2'd1:    off = slot - S3_BASE;
            default: off = slot - S1_BASE;
        endcase
        return off[2:0];
    endfunction

endpackage

// File: rtl/jt12_slot_cnt.sv
// Mod-24 slot counter advanced by clk_en. Exposes the value the counter is
// about to load so the caller can register outputs decoded from it, plus a
// flag that marks the 23->0 step.
module jt12_slot_cnt
    import jt12_sched_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clk_en,
    output logic [4:0] slot_nxt,
    output logic       wrap
);

    localparam logic [4:0] SLOT_LAST = 5'(SLOTS - 1);

    logic [4:0] slot_q;
    logic [4:0] slot_d;
    logic       wrap_s;

    // Next slot: hold without clk_en, otherwise step and wrap after the last slot
    always_comb begin
        slot_d = slot_q;
        wrap_s = 1'b0;
        if (clk_en) begin
            if (slot_q == SLOT_LAST) begin
                slot_d = 5'd0;
                wrap_s = 1'b1;
            end else begin
                slot_d = slot_q + 5'd1;
                wrap_s = 1'b0;
            end
        end else begin
            slot_d = slot_q;
            wrap_s = 1'b0;
        end
    end

    // Slot register; resets to the last slot so the first advance lands on slot 0
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_q <= SLOT_LAST;
        end else begin
            slot_q <= slot_d;
        end
    end

    assign slot_nxt = slot_d;
    assign wrap     = wrap_s;

endmodule

// File: rtl/jt12_acc_sched.sv
// Slot sequencer and per-channel configuration holder for the FM output
// accumulator. CPU writes wait in a one-entry buffer and are committed only
// at the frame wrap, so a channel never mixes two algorithms in one frame.
// Optional build macro: JT12_ACC_MUTE_EN adds a mute[5:0] input that forces
// the pan output of muted channels to 2'b00.
module jt12_acc_sched
    import jt12_sched_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clk_en,
    input  logic       cfg_we,
    input  logic [2:0] cfg_ch,
    input  logic [2:0] cfg_alg,
    input  logic [1:0] cfg_rl,
    input  logic       cfg_dac,
`ifdef JT12_ACC_MUTE_EN
    input  logic [5:0] mute,
`endif
    output logic       cfg_ready,
    output logic       s1_enters,
    output logic       s3_enters,
    output logic       s2_enters,
    output logic       s4_enters,
    output logic [2:0] ch,
    output logic [2:0] alg,
    output logic [1:0] rl,
    output logic       pcm_en,
    output logic       sample
);

    logic [4:0] slot_nxt_s;
    logic       wrap_s;

    jt12_slot_cnt u_slot_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .clk_en   (clk_en),
        .slot_nxt (slot_nxt_s),
        .wrap     (wrap_s)
    );

    // Pending buffer (ready_q=0 means an entry is waiting) and committed table
    logic       ready_q,   ready_d;
    logic [2:0] pend_ch_q, pend_ch_d;
    logic [2:0] pend_alg_q, pend_alg_d;
    logic [1:0] pend_rl_q, pend_rl_d;
    logic       pend_dac_q, pend_dac_d;
    logic [2:0] alg_tbl_q [NUM_CH];
    logic [2:0] alg_tbl_d [NUM_CH];
    logic [1:0] rl_tbl_q  [NUM_CH];
    logic [1:0] rl_tbl_d  [NUM_CH];
    logic       dac_q,     dac_d;

    // Registered slot outputs; enters is ordered {s1, s3, s2, s4}
    logic [3:0] enters_q, enters_d;
    logic [2:0] ch_q,     ch_d;
    logic [2:0] alg_q,    alg_d;
    logic [1:0] rl_q,     rl_d;
    logic       pcm_q,    pcm_d;
    logic       sample_q, sample_d;

    logic       accept_s;
    logic       commit_s;
    logic [1:0] grp_s;
    logic [2:0] chn_s;
    logic [2:0] sel_alg_s;
    logic [1:0] sel_rl_s;

    // Write handshake: capture into the empty buffer, apply it at the frame wrap
    always_comb begin
        accept_s   = cfg_we & ready_q;
        commit_s   = wrap_s & ~ready_q;
        ready_d    = ready_q;
        pend_ch_d  = pend_ch_q;
        pend_alg_d = pend_alg_q;
        pend_rl_d  = pend_rl_q;
        pend_dac_d = pend_dac_q;
        alg_tbl_d  = alg_tbl_q;
        rl_tbl_d   = rl_tbl_q;
        dac_d      = dac_q;
        if (accept_s) begin
            ready_d    = 1'b0;
            pend_ch_d  = cfg_ch;
            pend_alg_d = cfg_alg;
            pend_rl_d  = cfg_rl;
            pend_dac_d = cfg_dac;
        end else if (commit_s) begin
            ready_d = 1'b1;
            dac_d   = pend_dac_q;
            // Channel codes 6 and 7 match no entry: only dac takes effect
            for (int i = 0; i < NUM_CH; i++) begin
                if (pend_ch_q == 3'(i)) begin
                    alg_tbl_d[i] = pend_alg_q;
                    rl_tbl_d[i]  = pend_rl_q;
                end else begin
                    alg_tbl_d[i] = alg_tbl_q[i];
                    rl_tbl_d[i]  = rl_tbl_q[i];
                end
            end
        end else begin
            ready_d = ready_q;
        end
    end

    // Output decode from the slot being entered, using the post-commit table
    always_comb begin
        grp_s     = slot_group(slot_nxt_s);
        chn_s     = slot_ch(slot_nxt_s);
        sel_alg_s = 3'd0;
        sel_rl_s  = RL_RST;
        for (int i = 0; i < NUM_CH; i++) begin
            if (chn_s == 3'(i)) begin
                sel_alg_s = alg_tbl_d[i];
`ifdef JT12_ACC_MUTE_EN
                if (mute[i]) begin
                    sel_rl_s = 2'b00;
                end else begin
                    sel_rl_s = rl_tbl_d[i];
                end
`else
                sel_rl_s = rl_tbl_d[i];
`endif
            end else begin
                sel_alg_s = sel_alg_s;
            end
        end
        enters_d = enters_q;
        ch_d     = ch_q;
        alg_d    = alg_q;
        rl_d     = rl_q;
        pcm_d    = pcm_q;
        sample_d = 1'b0;
        if (clk_en) begin
            case (grp_s)
                2'd0:    enters_d = 4'b1000;
                2'd1:    enters_d = 4'b0100;
                2'd2:    enters_d = 4'b0010;
                2'd3:    enters_d = 4'b0001;
                default: enters_d = 4'b0000;
            endcase
            ch_d     = chn_s;
            alg_d    = sel_alg_s;
            rl_d     = sel_rl_s;
            pcm_d    = dac_d & (chn_s == 3'd5);
            sample_d = wrap_s;
        end else begin
            sample_d = 1'b0;
        end
    end

    // Configuration state: buffer, table and dac enable
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready_q    <= 1'b1;
            pend_ch_q  <= 3'd0;
            pend_alg_q <= 3'd0;
            pend_rl_q  <= 2'b00;
            pend_dac_q <= 1'b0;
            dac_q      <= 1'b0;
            for (int i = 0; i < NUM_CH; i++) begin
                alg_tbl_q[i] <= 3'd0;
                rl_tbl_q[i]  <= RL_RST;
            end
        end else begin
            ready_q    <= ready_d;
            pend_ch_q  <= pend_ch_d;
            pend_alg_q <= pend_alg_d;
            pend_rl_q  <= pend_rl_d;
            pend_dac_q <= pend_dac_d;
            dac_q      <= dac_d;
            alg_tbl_q  <= alg_tbl_d;
            rl_tbl_q   <= rl_tbl_d;
        end
    end

    // Slot-aligned output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            enters_q <= 4'b0000;
            ch_q     <= 3'd0;
            alg_q    <= 3'd0;
            rl_q     <= RL_RST;
            pcm_q    <= 1'b0;
            sample_q <= 1'b0;
        end else begin
            enters_q <= enters_d;
            ch_q     <= ch_d;
            alg_q    <= alg_d;
            rl_q     <= rl_d;
            pcm_q    <= pcm_d;
            sample_q <= sample_d;
        end
    end

    assign cfg_ready = ready_q;
    assign s1_enters = enters_q[3];
    assign s3_enters = enters_q[2];
    assign s2_enters = enters_q[1];
    assign s4_enters = enters_q[0];
    assign ch        = ch_q;
    assign alg       = alg_q;
    assign rl        = rl_q;
    assign pcm_en    = pcm_q;
    assign sample    = sample_q;

endmodule
